// File: rtl/mantissa_signed_add_pipe.sv
// Two-stage signed-magnitude mantissa adder with valid/ready on both ends.
// S1 applies signs (two's complement), S2 adds and returns to sign-magnitude.
module mantissa_signed_add_pipe #(
    parameter int MANT_W = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              sign_a,
    input  logic              sign_b,
    input  logic              sub,
    input  logic [MANT_W-1:0] mant_a,
    input  logic [MANT_W-1:0] mant_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sign,
    output logic [MANT_W:0]   out_mant,
    output logic              out_zero
);
    localparam int XW = MANT_W + 2;

    logic              eb;
    logic              diff_d;
    logic [XW-1:0]     ext_a;
    logic [XW-1:0]     ext_b;
    logic [XW-1:0]     op_a_d;
    logic [XW-1:0]     op_b_d;

    logic              s1_valid_q;
    logic              s1_diff_q;
    logic              s1_sign_q;
    logic [XW-1:0]     s1_a_q;
    logic [XW-1:0]     s1_b_q;

    logic              s2_valid_q;
    logic              s2_adv;
    logic              s1_adv;

    logic [XW-1:0]     sum;
    logic [MANT_W:0]   neg_mant;
    logic              out_sign_d;
    logic [MANT_W:0]   out_mant_d;
    logic              out_zero_d;
    logic              out_sign_q;
    logic [MANT_W:0]   out_mant_q;
    logic              out_zero_q;

    assign s2_adv   = ~s2_valid_q | out_ready;
    assign s1_adv   = ~s1_valid_q | s2_adv;
    assign in_ready = s1_adv & ~rst;

    // With differing signs exactly one operand is negative: A if sign_a,
    // otherwise B (its effective sign is then 1).
    always_comb begin
        eb     = sign_b ^ sub;
        diff_d = sign_a ^ eb;
        ext_a  = {2'b00, mant_a};
        ext_b  = {2'b00, mant_b};
        op_a_d = ext_a;
        op_b_d = ext_b;
        if (diff_d) begin
            if (sign_a) begin
                op_a_d = -ext_a;
            end else begin
                op_b_d = -ext_b;
            end
        end
    end

    always_comb begin
        sum        = s1_a_q + s1_b_q;
        neg_mant   = -sum[MANT_W:0];
        out_sign_d = s1_sign_q;
        out_mant_d = sum[MANT_W:0];
        if (s1_diff_q) begin
            out_sign_d = sum[XW-1];
            if (sum[XW-1]) begin
                out_mant_d = neg_mant;
            end
        end
        out_zero_d = (out_mant_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            out_sign_q <= 1'b0;
            out_mant_q <= '0;
            out_zero_q <= 1'b0;
        end else begin
            if (s1_adv) begin
                s1_valid_q <= in_valid;
            end
            if (s2_adv) begin
                s2_valid_q <= s1_valid_q;
            end
            if (s2_adv && s1_valid_q) begin
                out_sign_q <= out_sign_d;
                out_mant_q <= out_mant_d;
                out_zero_q <= out_zero_d;
            end
        end
    end

    // Operand registers are qualified by s1_valid_q, so they need no reset.
    always_ff @(posedge clk) begin
        if (s1_adv && in_valid) begin
            s1_a_q    <= op_a_d;
            s1_b_q    <= op_b_d;
            s1_diff_q <= diff_d;
            s1_sign_q <= sign_a;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_sign  = out_sign_q;
    assign out_mant  = out_mant_q;
    assign out_zero  = out_zero_q;

endmodule

// File: doc/mantissa_signed_add_pipe.md
# mantissa_signed_add_pipe

Two-stage pipelined signed-magnitude mantissa adder for the floating-point adder datapath, placed after exponent alignment and before normalisation. It applies the effective operation and signs to two aligned mantissas, two's-complements the negative operand, adds, and converts the result back to sign-magnitude. Mantissa width is parametrised, and both ends use valid/ready handshakes with full back-pressure.

## Interface
- MANT_W, 24, mantissa width including hidden bit (≥4)
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand pair present
- in_ready  out  1  stage accepts operands this cycle
- sign_a  in  1  sign of operand A
- sign_b  in  1  sign of operand B
- sub  in  1  1 = compute A − B, 0 = A + B
- mant_a  in  MANT_W  aligned magnitude of A
- mant_b  in  MANT_W  aligned magnitude of B
- out_valid  out  1  result present
- out_ready  in  1  downstream consumes result
- out_sign  out  1  result sign
- out_mant  out  MANT_W+1  result magnitude; MSB is carry-out
- out_zero  out  1  result magnitude is zero

## Operation
- Effective B sign: eb = sign_b ^ sub. Diff = sign_a ^ eb.
- Stage 1 (S1 register): zero-extend both mantissas to MANT_W+2 bits. If diff=1, replace the operand whose sign is 1 with its two's complement modulo 2^(MANT_W+2). If diff=0, pass both unchanged. Register the operands, diff, and the common sign sign_a.
- Stage 2 (S2 register): sum = opA + opB modulo 2^(MANT_W+2).
  - diff=0: out_mant = sum[MANT_W:0], out_sign = common sign. The carry lands in the MSB.
  - diff=1, sum[MANT_W+1]=1: out_sign = 1, out_mant = (−sum)[MANT_W:0].
  - diff=1, sum[MANT_W+1]=0: out_sign = 0, out_mant = sum[MANT_W:0].
- out_zero = (out_mant == 0).
- Exact cancellation (diff=1, equal magnitudes) always gives out_sign = 0 (+0).
- With diff=0 and both magnitudes zero, out_sign keeps the common sign (−0 + −0 = −0).
- No overflow is possible: the MANT_W+2 bit internal width covers every case.

## Timing
- Handshake: a transfer occurs when valid & ready are both high on a clock edge. Results leave in acceptance order.
- Advance conditions: s2_adv = ~s2_valid | out_ready; s1_adv = ~s1_valid | s2_adv.
- in_ready = s1_adv & ~rst. This is combinational from out_ready; the path is intended.
- Latency: 2 cycles from input acceptance to out_valid, with no stall.
- Throughput: 1 result per cycle while out_ready = 1.
- While out_valid = 1 and out_ready = 0, all outputs hold stable. S1 fills, then in_ready falls.
- Reset (synchronous): the edge with rst = 1 clears s1_valid and s2_valid. Reset values: out_valid = 0, out_sign = 0, out_mant = 0, out_zero = 0.
- Reset mid-operation: in-flight operands are discarded and never appear at the output. in_valid is ignored while rst = 1.
- Simultaneous accept and drain on one edge: S2 loads from S1 and S1 loads new operands. No bubble is inserted.

## Test plan
- Same-sign add, MANT_W=24: sa=0, sb=0, sub=0, A=0x800000, B=0x800000 -> out_mant=0x1000000, out_sign=0, out_zero=0; out_valid exactly 2 cycles after accept.
- Mixed signs: sa=1, sb=0, sub=0, A=0xC00000, B=0x800000 -> out_mant=0x400000, out_sign=1. Swap roles (sa=0, sb=1) -> out_mant=0x400000, out_sign=0.
- Cancellation: sa=sb=0, sub=1, A=B=0xA00000 -> out_mant=0, out_zero=1, out_sign=0. Negative zeros: sa=sb=1, sub=0, A=B=0 -> out_zero=1, out_sign=1.
- Back-pressure: issue 3 back-to-back ops with out_ready=0 for 4 cycles -> in_ready drops after the 2nd accept; outputs stay constant while stalled; all 3 results emerge in order on consecutive cycles once out_ready=1.
- Reset mid-flight: 2 ops in flight, assert rst for 1 cycle -> out_valid=0 on the following cycle; neither result is ever presented; the next op completes with 2-cycle latency.
- Parameter sweep, MANT_W=11: sa=sb=0, A=0x7FF, B=0x001 -> out_mant=0x800. Then sub=1, A=0x001, B=0x7FF -> out_mant=0x7FE, out_sign=1.
